// File: rtl/im_boot_pkg.sv
// im_boot_pkg: shared state encoding and sizing constants for the instruction-memory boot controller.
package im_boot_pkg;
   localparam int IM_ADDR_W      = 14;
   localparam int IM_DATA_W      = 32;
   localparam int BYTES_PER_WORD = IM_DATA_W / 8;
   localparam int LEN_BYTES      = 2;
   typedef enum logic [2:0] {S_RUN, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_FIN} im_boot_state_t;
endpackage

// File: rtl/im_boot_ctrl_byte_packer.sv
// byte_packer: shifts bytes in big-endian order and flags each completed word for one cycle.
import im_boot_pkg::*;

module byte_packer #(
   parameter int DATA_W = IM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr_i,
   input  logic [7:0]        byte_i,
   input  logic              vld_i,
   output logic [DATA_W-1:0] word_o,
   output logic              word_vld_o
);
   localparam int BPW = DATA_W / 8;
   localparam int CW  = BPW > 1 ? $clog2(BPW) : 1;
   logic [DATA_W-1:0] word_q, word_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              vld_q, vld_d;
   logic              full;
   assign full = cnt_q == CW'(BPW - 1);
   always_comb begin
      word_d = clr_i ? '0 : vld_i ? {word_q[DATA_W-9:0], byte_i} : word_q;
      cnt_d  = (clr_i || (vld_i && full)) ? '0 : vld_i ? cnt_q + 1'b1 : cnt_q;
      vld_d  = !clr_i && vld_i && full;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
      end
   end
   assign word_o     = word_q;
   assign word_vld_o = vld_q;
endmodule

// File: rtl/im_boot_ctrl.sv
// im_boot_ctrl: shares the instruction-memory port between CPU fetch and a UART program loader.
// Optional trailing checksum byte enabled by defining BOOT_CHECKSUM_EN.
import im_boot_pkg::*;

module im_boot_ctrl #(
   parameter int ADDR_W = IM_ADDR_W,
   parameter int DATA_W = BYTES_PER_WORD * 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              boot_req,
   input  logic [7:0]        rx_byte,
   input  logic              rx_vld,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rd_en,
   output logic              cpu_stall,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err
);
   localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
`ifdef BOOT_CHECKSUM_EN
   localparam im_boot_state_t S_TAIL = S_CSUM;
`else
   localparam im_boot_state_t S_TAIL = S_FIN;
`endif
   im_boot_state_t          state_q, state_d;
   logic [ADDR_W:0]         wcnt_q, wcnt_d, n_q, n_d, n_len;
   logic [7:0]              len_hi_q, len_hi_d;
   logic                    err_q, err_d;
   logic [LEN_BYTES*8-1:0]  n_full;
   logic                    len_over, last_wr, pk_vld, pk_clr, pk_wvld;
   logic [DATA_W-1:0]       pk_word;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]              csum_q, csum_d;
   logic                    pend_q, pend_d;
`endif
   assign n_full   = {len_hi_q, rx_byte};
   assign len_over = n_full > (LEN_BYTES*8)'(MAX_N);
   assign n_len    = len_over ? MAX_N : n_full[ADDR_W:0];
   assign last_wr  = state_q == S_DATA && pk_wvld && wcnt_q == n_q - 1'b1;
   // a byte landing in the final write cycle is past the image, never data
   assign pk_vld   = rx_vld && state_q == S_DATA && !last_wr;
   assign pk_clr   = state_q == S_RUN && boot_req;
   byte_packer #(.DATA_W(DATA_W)) u_packer (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (pk_clr),
      .byte_i     (rx_byte),
      .vld_i      (pk_vld),
      .word_o     (pk_word),
      .word_vld_o (pk_wvld)
   );
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      n_d      = n_q;
      len_hi_d = len_hi_q;
      err_d    = err_q;
`ifdef BOOT_CHECKSUM_EN
      csum_d   = csum_q;
      pend_d   = pend_q;
`endif
      case (state_q)
         S_RUN: if (boot_req) begin
            state_d = S_LEN_HI;
            wcnt_d  = '0;
            err_d   = 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_d  = '0;
            pend_d  = 1'b0;
`endif
         end
         S_LEN_HI: if (rx_vld) begin
            state_d  = S_LEN_LO;
            len_hi_d = rx_byte;
`ifdef BOOT_CHECKSUM_EN
            csum_d   = csum_q ^ rx_byte;
`endif
         end
         S_LEN_LO: if (rx_vld) begin
            state_d = n_len == '0 ? S_TAIL : S_DATA;
            n_d     = n_len;
            err_d   = err_q | len_over;
`ifdef BOOT_CHECKSUM_EN
            csum_d  = csum_q ^ rx_byte;
`endif
         end
         S_DATA: begin
            wcnt_d  = pk_wvld ? wcnt_q + 1'b1 : wcnt_q;
            state_d = last_wr ? S_TAIL : S_DATA;
`ifdef BOOT_CHECKSUM_EN
            csum_d  = pk_vld ? csum_q ^ rx_byte : csum_q;
            // checksum arriving back-to-back with the last write is judged now, retired in CSUM
            if (last_wr && rx_vld) begin
               pend_d = 1'b1;
               err_d  = err_q | (rx_byte != csum_q);
            end
`endif
         end
`ifdef BOOT_CHECKSUM_EN
         S_CSUM: if (pend_q || rx_vld) begin
            state_d = S_FIN;
            err_d   = err_q | (!pend_q && rx_byte != csum_q);
         end
`endif
         default: state_d = S_RUN;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_RUN;
         wcnt_q   <= '0;
         n_q      <= '0;
         len_hi_q <= '0;
         err_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         csum_q   <= '0;
         pend_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         n_q      <= n_d;
         len_hi_q <= len_hi_d;
         err_q    <= err_d;
`ifdef BOOT_CHECKSUM_EN
         csum_q   <= csum_d;
         pend_q   <= pend_d;
`endif
      end
   end
   assign cpu_stall = state_q != S_RUN;
   assign load_busy = cpu_stall;
   assign load_done = state_q == S_FIN;
   assign load_err  = err_q;
   assign mem_we    = state_q == S_DATA && pk_wvld;
   assign mem_addr  = state_q == S_RUN ? cpu_addr : wcnt_q[ADDR_W-1:0];
   assign mem_rd_en = state_q == S_RUN && cpu_rd_en;
   assign mem_wdata = pk_word;
endmodule

// File: tb/tb_im_boot_ctrl.sv
// tb_im_boot_ctrl: directed self-checking bench for im_boot_ctrl with a write-capturing memory model.
module tb_im_boot_ctrl;
   logic        clk = 1'b0, rst = 1'b1, boot_req = 1'b0, rx_vld = 1'b0, cpu_rd_en = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic [13:0] cpu_addr = 14'h0;
   logic        cpu_stall, mem_rd_en, mem_we, load_busy, load_done, load_err;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   int total = 0, bad = 0;
   int wr_cnt = 0, done_cnt = 0, zero_w = 0, jmp = 0;
   logic [13:0] prev_addr = 14'h0, last_addr = 14'h0;
   logic [31:0] mem_m [0:16383];
   logic [7:0]  xs = 8'h00;

   im_boot_ctrl dut (
      .clk(clk), .rst(rst), .boot_req(boot_req), .rx_byte(rx_byte), .rx_vld(rx_vld),
      .cpu_addr(cpu_addr), .cpu_rd_en(cpu_rd_en), .cpu_stall(cpu_stall), .mem_addr(mem_addr),
      .mem_rd_en(mem_rd_en), .mem_we(mem_we), .mem_wdata(mem_wdata), .load_busy(load_busy),
      .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   // memory side: capture writes on negedge like the real RAM
   always @(negedge clk) begin
      if (mem_we) begin
         mem_m[mem_addr] <= mem_wdata;
         wr_cnt    <= wr_cnt + 1;
         last_addr <= mem_addr;
         prev_addr <= mem_addr;
         if (mem_addr == 14'h0) zero_w <= zero_w + 1;
         if (mem_addr != 14'h0 && mem_addr != prev_addr + 14'd1) jmp <= jmp + 1;
      end
      if (load_done) done_cnt <= done_cnt + 1;
   end

   task automatic drive(input logic [7:0] b);
      rx_byte = b;
      rx_vld  = 1'b1;
      xs      = xs ^ b;
      @(posedge clk); #1;
      rx_vld  = 1'b0;
   endtask

   task automatic boot();
      boot_req = 1'b1;
      xs       = 8'h00;
      @(posedge clk); #1;
      boot_req = 1'b0;
   endtask

   task automatic tail();
`ifdef BOOT_CHECKSUM_EN
      drive(xs);
`endif
   endtask

   task automatic wait_done(input int d0, input int lim, output bit ok);
      ok = done_cnt != d0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(posedge clk); #1;
         ok = done_cnt != d0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cpu_addr = 14'h0123; cpu_rd_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      total++; if (mem_addr !== 14'h0123) begin bad++; $display("FAIL rst_addr: got %h want 0123", mem_addr); end
      total++; if (mem_rd_en !== 1'b1) begin bad++; $display("FAIL rst_rd_en: got %b want 1", mem_rd_en); end
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", cpu_stall); end
      total++; if (load_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", load_busy); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
      total++; if (load_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", load_done); end
      total++; if (load_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", load_err); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
      @(posedge clk); #1;
   endtask

   task automatic test_two_word();
      int w0 = wr_cnt, d0 = done_cnt;
      boot();
      total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL tw_stall: got %b want 1", cpu_stall); end
      total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL tw_rd_en: got %b want 0", mem_rd_en); end
      drive(8'h00); drive(8'h02); drive(8'hDE); drive(8'hAD); drive(8'hBE); drive(8'hEF);
      total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 14'h0, 32'hDEADBEEF}) begin bad++; $display("FAIL tw_wr0: got we=%b a=%h d=%h want we=1 a=0 d=deadbeef", mem_we, mem_addr, mem_wdata); end
      drive(8'h01); drive(8'h02); drive(8'h03); drive(8'h04);
      total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 14'h1, 32'h01020304}) begin bad++; $display("FAIL tw_wr1: got we=%b a=%h d=%h want we=1 a=1 d=01020304", mem_we, mem_addr, mem_wdata); end
      tail();
      @(posedge clk); #1;
      total++; if ({load_done, cpu_stall} !== 2'b11) begin bad++; $display("FAIL tw_done: got done=%b stall=%b want 1 1", load_done, cpu_stall); end
      @(posedge clk); #1;
      total++; if ({load_done, cpu_stall} !== 2'b00) begin bad++; $display("FAIL tw_resume: got done=%b stall=%b want 0 0", load_done, cpu_stall); end
      total++; if (mem_addr !== 14'h0123) begin bad++; $display("FAIL tw_pass: got %h want 0123", mem_addr); end
      total++; if (mem_m[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL tw_mem0: got %h want deadbeef", mem_m[0]); end
      total++; if (mem_m[1] !== 32'h01020304) begin bad++; $display("FAIL tw_mem1: got %h want 01020304", mem_m[1]); end
      total++; if (wr_cnt - w0 !== 2) begin bad++; $display("FAIL tw_nwr: got %0d want 2", wr_cnt - w0); end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL tw_ndone: got %0d want 1", done_cnt - d0); end
      total++; if (load_err !== 1'b0) begin bad++; $display("FAIL tw_err: got %b want 0", load_err); end
   endtask

   task automatic test_zero_and_ignore();
      int w0 = wr_cnt, d0;
      bit ok;
      boot_req = 1'b1; rx_vld = 1'b1; rx_byte = 8'h55; xs = 8'h00;
      @(posedge clk); #1;
      boot_req = 1'b0; rx_vld = 1'b0;
      drive(8'h00); drive(8'h00); tail();
      total++; if (load_done !== 1'b1) begin bad++; $display("FAIL zl_done: got %b want 1", load_done); end
      total++; if (wr_cnt - w0 !== 0) begin bad++; $display("FAIL zl_nwr: got %0d want 0", wr_cnt - w0); end
      @(posedge clk); #1;
      total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL zl_stall: got %b want 0", cpu_stall); end
      d0 = done_cnt;
      boot();
      drive(8'h00); drive(8'h01); drive(8'hAA);
      boot_req = 1'b1;
      @(posedge clk); #1;
      boot_req = 1'b0;
      drive(8'hBB); drive(8'hCC); drive(8'hDD);
      total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 14'h0, 32'hAABBCCDD}) begin bad++; $display("FAIL ig_wr: got we=%b a=%h d=%h want we=1 a=0 d=aabbccdd", mem_we, mem_addr, mem_wdata); end
      tail();
      wait_done(d0, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL ig_timeout: got no load_done want load_done"); end
      total++; if (load_err !== 1'b0) begin bad++; $display("FAIL ig_err: got %b want 0", load_err); end
      total++; if (wr_cnt - w0 !== 1) begin bad++; $display("FAIL ig_nwr: got %0d want 1", wr_cnt - w0); end
   endtask

   task automatic test_reset_mid();
      int d0;
      bit ok;
      boot();
      drive(8'h00); drive(8'h02); drive(8'hDE); drive(8'hAD); drive(8'hBE); drive(8'hEF);
      drive(8'h01); drive(8'h02);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if ({cpu_stall, load_busy, load_done} !== 3'b000) begin bad++; $display("FAIL rm_state: got stall=%b busy=%b done=%b want 0 0 0", cpu_stall, load_busy, load_done); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rm_wdata: got %h want 0", mem_wdata); end
      d0 = done_cnt;
      boot();
      drive(8'h00); drive(8'h01); drive(8'hCA); drive(8'hFE); drive(8'hBA); drive(8'hBE);
      total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 14'h0, 32'hCAFEBABE}) begin bad++; $display("FAIL rm_wr: got we=%b a=%h d=%h want we=1 a=0 d=cafebabe", mem_we, mem_addr, mem_wdata); end
      tail();
      wait_done(d0, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL rm_timeout: got no load_done want load_done"); end
      total++; if (mem_m[0] !== 32'hCAFEBABE) begin bad++; $display("FAIL rm_mem0: got %h want cafebabe", mem_m[0]); end
   endtask

   task automatic test_overflow();
      int w0, z0, j0, d0;
      bit ok;
      d0 = done_cnt;
      boot();
      drive(8'h7F); drive(8'hFF);
      total++; if ({load_err, cpu_stall} !== 2'b11) begin bad++; $display("FAIL ov_err: got err=%b stall=%b want 1 1", load_err, cpu_stall); end
      w0 = wr_cnt; z0 = zero_w; j0 = jmp;
      for (int i = 0; i < 65536; i++) drive(8'(i));
      tail();
      wait_done(d0, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL ov_timeout: got no load_done want load_done"); end
      total++; if (wr_cnt - w0 !== 16384) begin bad++; $display("FAIL ov_nwr: got %0d want 16384", wr_cnt - w0); end
      total++; if (zero_w - z0 !== 1) begin bad++; $display("FAIL ov_zero: got %0d want 1", zero_w - z0); end
      total++; if (jmp - j0 !== 0) begin bad++; $display("FAIL ov_seq: got %0d want 0", jmp - j0); end
      total++; if (last_addr !== 14'h3FFF) begin bad++; $display("FAIL ov_last: got %h want 3fff", last_addr); end
      total++; if (mem_m[0] !== 32'h00010203) begin bad++; $display("FAIL ov_mem0: got %h want 00010203", mem_m[0]); end
      total++; if (mem_m[16383] !== 32'hFCFDFEFF) begin bad++; $display("FAIL ov_memlast: got %h want fcfdfeff", mem_m[16383]); end
      total++; if (load_err !== 1'b1) begin bad++; $display("FAIL ov_sticky: got %b want 1", load_err); end
      d0 = done_cnt;
      boot();
      total++; if (load_err !== 1'b0) begin bad++; $display("FAIL ov_clear: got %b want 0", load_err); end
      drive(8'h00); drive(8'h00); tail();
      wait_done(d0, 10, ok);
      total++; if (!ok) begin bad++; $display("FAIL ov_clr_timeout: got no load_done want load_done"); end
   endtask

`ifdef BOOT_CHECKSUM_EN
   task automatic test_checksum();
      int d0 = done_cnt;
      bit ok;
      boot();
      drive(8'h00); drive(8'h01); drive(8'h11); drive(8'h22); drive(8'h33); drive(8'h44); drive(8'h45);
      wait_done(d0, 10, ok);
      total++; if (!ok || load_err !== 1'b0) begin bad++; $display("FAIL cs_good: got ok=%b err=%b want 1 0", ok, load_err); end
      d0 = done_cnt;
      mem_m[0] = 32'h0;
      boot();
      drive(8'h00); drive(8'h01); drive(8'h11); drive(8'h22); drive(8'h33); drive(8'h44); drive(8'h00);
      wait_done(d0, 10, ok);
      total++; if (!ok || load_err !== 1'b1) begin bad++; $display("FAIL cs_bad: got ok=%b err=%b want 1 1", ok, load_err); end
      total++; if (mem_m[0] !== 32'h11223344) begin bad++; $display("FAIL cs_mem: got %h want 11223344", mem_m[0]); end
   endtask
`endif

   initial begin
      test_reset();
      test_two_word();
      test_zero_and_ignore();
      test_reset_mid();
      test_overflow();
`ifdef BOOT_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
